// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - shared constants, FSM state type and reject-bound helper for the eta sampler
package dilithium_pkg;

    localparam int DIL_N         = 256;
    localparam int SHAKE256_RATE = 136;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_FETCH,
        S_UNPACK,
        S_FIN
    } eta_state_t;

    // Nibbles strictly below this bound are accepted.
    function automatic logic [4:0] eta_reject_bound(input int eta);
        return (eta == 4) ? 5'd9 : 5'd15;
    endfunction

endpackage

// File: rtl/eta_nibble_decode.sv
// rtl/eta_nibble_decode.sv - combinational nibble -> (accept, signed coefficient) for ETA 2 or 4
module eta_nibble_decode
    import dilithium_pkg::*;
#(
    parameter int ETA = 2
) (
    input  logic              [3:0] i_nibble,
    output logic                    o_accept,
    output logic signed       [3:0] o_coeff
);

    assign o_accept = ({1'b0, i_nibble} < eta_reject_bound(ETA));

    generate
        if (ETA == 2) begin : g_eta2
            // t mod 5 for t in 0..14 by two conditional subtracts
            logic [3:0] w_mod5;
            assign w_mod5  = i_nibble
                           - ((i_nibble >= 4'd5)  ? 4'd5 : 4'd0)
                           - ((i_nibble >= 4'd10) ? 4'd5 : 4'd0);
            assign o_coeff = signed'(4'd2 - w_mod5);
        end else begin : g_eta4
            assign o_coeff = signed'(4'd4 - i_nibble);
        end
    endgenerate

endmodule

// File: rtl/poly_eta_sampler.sv
// rtl/poly_eta_sampler.sv - streaming eta sampler: XOF byte beats -> rejection-sampled poly coefficients
// Optional statistics outputs enabled by POLY_ETA_SAMPLER_STATS_EN.
module poly_eta_sampler
    import dilithium_pkg::*;
#(
    parameter int  ETA     = 2,
    parameter int  N       = DIL_N,
    parameter int  COEFF_W = 32,
    parameter int  BPB     = 8,
    localparam int AW      = $clog2(N)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [511:0]       i_seed,
    input  logic [15:0]        i_nonce,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_xof_start,
    output logic [511:0]       o_xof_seed,
    output logic [15:0]        o_xof_nonce,
    input  logic [8*BPB-1:0]   i_xof_data,
    input  logic               i_xof_valid,
    output logic               o_xof_ready,
    output logic               o_xof_stop,
    output logic               o_coef_we,
    output logic [AW-1:0]      o_coef_addr,
    output logic [COEFF_W-1:0] o_coef_data
`ifdef POLY_ETA_SAMPLER_STATS_EN
    ,
    output logic [15:0]        o_rej_cnt,
    output logic [7:0]         o_blk_cnt
`endif
);

    localparam int NW = $clog2(2 * BPB) > 0 ? $clog2(2 * BPB) : 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [NW-1:0] LAST_NIB = NW'(2 * BPB - 1);
    localparam logic [CW-1:0] LAST_CTR = CW'(N - 1);

    generate
        if (ETA != 2 && ETA != 4) begin : g_bad_eta
            $error("poly_eta_sampler: ETA must be 2 or 4");
        end
        if ((BPB != 1 && BPB != 2 && BPB != 4 && BPB != 8) || (SHAKE256_RATE % BPB) != 0) begin : g_bad_bpb
            $error("poly_eta_sampler: BPB must be 1, 2, 4 or 8");
        end
    endgenerate

    eta_state_t        r_state;
    eta_state_t        w_next;
    logic [511:0]      r_seed;
    logic [15:0]       r_nonce;
    logic [8*BPB-1:0]  r_beat;
    logic [NW-1:0]     r_nib;
    logic [CW-1:0]     r_ctr;

    logic              w_accept;
    logic signed [3:0] w_coeff;
    logic [3:0]        w_nibble;
    logic              w_write;

    assign w_nibble = r_beat[{r_nib, 2'b00} +: 4];

    eta_nibble_decode #(.ETA(ETA)) u_decode (
        .i_nibble (w_nibble),
        .o_accept (w_accept),
        .o_coeff  (w_coeff)
    );

    assign w_write = (r_state == S_UNPACK) && w_accept;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_KICK;
            S_KICK:   w_next = S_FETCH;
            S_FETCH:  if (i_xof_valid) w_next = S_UNPACK;
            S_UNPACK: begin
                // The final accept ends the poly even mid-beat; leftover nibbles are dropped.
                if (w_write && r_ctr == LAST_CTR) w_next = S_FIN;
                else if (r_nib == LAST_NIB)       w_next = S_FETCH;
            end
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_seed  <= '0;
            r_nonce <= '0;
            r_beat  <= '0;
            r_nib   <= '0;
            r_ctr   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_seed  <= i_seed;
                    r_nonce <= i_nonce;
                    r_ctr   <= '0;
                end
                S_FETCH: if (i_xof_valid) begin
                    r_beat <= i_xof_data;
                    r_nib  <= '0;
                end
                S_UNPACK: begin
                    r_nib <= r_nib + NW'(1);
                    if (w_accept) r_ctr <= r_ctr + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_busy      = (r_state == S_KICK) || (r_state == S_FETCH) || (r_state == S_UNPACK);
    assign o_done      = (r_state == S_FIN);
    assign o_xof_stop  = (r_state == S_FIN);
    assign o_xof_start = (r_state == S_KICK);
    assign o_xof_ready = (r_state == S_FETCH);
    assign o_xof_seed  = r_seed;
    assign o_xof_nonce = r_nonce;
    assign o_coef_we   = w_write;
    assign o_coef_addr = w_write ? r_ctr[AW-1:0] : '0;
    assign o_coef_data = w_write ? {{(COEFF_W-4){w_coeff[3]}}, w_coeff} : '0;

`ifdef POLY_ETA_SAMPLER_STATS_EN
    localparam logic [7:0] POS_STEP = 8'(BPB);
    localparam logic [7:0] POS_LAST = 8'(SHAKE256_RATE - BPB);

    logic [15:0] r_rej_cnt;
    logic [7:0]  r_blk_cnt;
    logic [7:0]  r_blk_pos;

    // Beats never straddle a block, so a block is touched when a beat starts at offset 0.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rej_cnt <= '0;
            r_blk_cnt <= '0;
            r_blk_pos <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_rej_cnt <= '0;
            r_blk_cnt <= '0;
            r_blk_pos <= '0;
        end else begin
            if (r_state == S_FETCH && i_xof_valid) begin
                if (r_blk_pos == 8'd0 && r_blk_cnt != 8'hFF) r_blk_cnt <= r_blk_cnt + 8'd1;
                r_blk_pos <= (r_blk_pos == POS_LAST) ? 8'd0 : r_blk_pos + POS_STEP;
            end
            if (r_state == S_UNPACK && !w_accept && r_rej_cnt != 16'hFFFF)
                r_rej_cnt <= r_rej_cnt + 16'd1;
        end
    end

    assign o_rej_cnt = r_rej_cnt;
    assign o_blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_poly_eta_sampler.sv
// tb/tb_poly_eta_sampler.sv - scoreboard bench: ETA=2/N=256 and ETA=4/N=16 instances fed from byte queues
module tb_poly_eta_sampler;

    localparam int BPB = 8;
    localparam int N0  = 256;
    localparam int N1  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             start  [2];
    logic [511:0]     seed;
    logic [15:0]      nonce;
    logic             busy   [2];
    logic             done   [2];
    logic             xstart [2];
    logic             xready [2];
    logic             xstop  [2];
    logic             we     [2];
    logic             xvalid [2];
    logic [511:0]     xseed  [2];
    logic [15:0]      xnonce [2];
    logic [8*BPB-1:0] xdata  [2];
    logic [31:0]      cdata  [2];
    logic [31:0]      aw     [2];
    logic [7:0]       addr0;
    logic [3:0]       addr1;
    assign aw[0] = {24'd0, addr0};
    assign aw[1] = {28'd0, addr1};
`ifdef POLY_ETA_SAMPLER_STATS_EN
    logic [15:0] rej [2];
    logic [7:0]  blk [2];
`endif

    poly_eta_sampler #(.ETA(2), .N(N0), .COEFF_W(32), .BPB(BPB)) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_start(start[0]), .i_seed(seed), .i_nonce(nonce),
        .o_busy(busy[0]), .o_done(done[0]), .o_xof_start(xstart[0]),
        .o_xof_seed(xseed[0]), .o_xof_nonce(xnonce[0]),
        .i_xof_data(xdata[0]), .i_xof_valid(xvalid[0]), .o_xof_ready(xready[0]), .o_xof_stop(xstop[0]),
        .o_coef_we(we[0]), .o_coef_addr(addr0), .o_coef_data(cdata[0])
`ifdef POLY_ETA_SAMPLER_STATS_EN
        , .o_rej_cnt(rej[0]), .o_blk_cnt(blk[0])
`endif
    );

    poly_eta_sampler #(.ETA(4), .N(N1), .COEFF_W(32), .BPB(BPB)) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_start(start[1]), .i_seed(seed), .i_nonce(nonce),
        .o_busy(busy[1]), .o_done(done[1]), .o_xof_start(xstart[1]),
        .o_xof_seed(xseed[1]), .o_xof_nonce(xnonce[1]),
        .i_xof_data(xdata[1]), .i_xof_valid(xvalid[1]), .o_xof_ready(xready[1]), .o_xof_stop(xstop[1]),
        .o_coef_we(we[1]), .o_coef_addr(addr1), .o_coef_data(cdata[1])
`ifdef POLY_ETA_SAMPLER_STATS_EN
        , .o_rej_cnt(rej[1]), .o_blk_cnt(blk[1])
`endif
    );

    logic [7:0]  src_q [2][$];
    logic [63:0] exp_q [2][$];
    logic [63:0] wlog  [2][$];
    int          vmode [2];
    int          beats [2];
    int          nwr   [2];
    int          first_beats [2];
    int          done_cnt [2];
    bit          rdy_prev [2];
    int          vectors = 0;
    int          miscompares = 0;
    int          ready_viol = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor (scoreboard pop) then XOF source, in that order, each falling edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            xvalid[k] = 1'b0; xdata[k] = '0; rdy_prev[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (we[k]) begin
                    logic [63:0] act;
                    act = {aw[k], cdata[k]};
                    if (nwr[k] == 0) first_beats[k] = beats[k];
                    nwr[k]++;
                    wlog[k].push_back(act);
                    if (exp_q[k].size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_write inst%0d: got %0h required no write", k, act);
                    end else begin
                        check($sformatf("coef_inst%0d", k), act, exp_q[k].pop_front());
                    end
                end
                if (xready[k] && (we[k] || !busy[k])) ready_viol++;
                if (done[k]) done_cnt[k]++;
                if (xvalid[k] && rdy_prev[k] && src_q[k].size() >= BPB) begin
                    repeat (BPB) void'(src_q[k].pop_front());
                    beats[k]++;
                end
                rdy_prev[k] = xready[k];
                if (src_q[k].size() >= BPB && (vmode[k] == 0 || $urandom_range(0, 1) == 1)) begin
                    xvalid[k] = 1'b1;
                    for (int b = 0; b < BPB; b++) xdata[k][8*b +: 8] = src_q[k][b];
                end else begin
                    xvalid[k] = 1'b0;
                end
            end
        end
    end

    // Golden model: walk the queued stream nibble by nibble and push expected writes.
    task automatic load(input int k, input int eta, input int n);
        int c;
        c = 0;
        exp_q[k].delete(); wlog[k].delete();
        beats[k] = 0; nwr[k] = 0; done_cnt[k] = 0; first_beats[k] = -1;
        for (int i = 0; i < src_q[k].size() && c < n; i++) begin
            for (int h = 0; h < 2 && c < n; h++) begin
                int t;
                int cf;
                bit acc;
                t = int'((src_q[k][i] >> (4 * h)) & 8'h0F);
                if (eta == 2) begin acc = (t < 15); cf = 2 - (t % 5); end
                else          begin acc = (t < 9);  cf = 4 - t;       end
                if (acc) begin
                    exp_q[k].push_back({32'(c), 32'(cf)});
                    c++;
                end
            end
        end
    endtask

    task automatic run(input int k, input int n, input bit poke, output int lat);
        logic [511:0] seed_save;
        int unsigned t0;
        int g;
        seed_save = seed;
        @(negedge clk);
        start[k] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start[k] = 1'b0;
        check("xof_start_latency", {63'd0, xstart[k]}, 64'd1);
        check("xof_seed_nonce", {xseed[k][511:464], xnonce[k]}, {seed[511:464], nonce});
        g = 0;
        while (!done[k] && g < 20000) begin
            @(negedge clk);
            g++;
            if (poke && g == 50) begin
                seed = ~seed_save;
                start[k] = 1'b1;
            end else begin
                start[k] = 1'b0;
            end
        end
        lat = int'(cyc - t0);
        seed = seed_save;
        check("done_seen", {63'd0, done[k]}, 64'd1);
        check("seed_held", {xseed[k][511:464], xnonce[k]}, {seed_save[511:464], nonce});
        @(negedge clk);
        check("done_one_cycle", {62'd0, busy[k], done[k]}, 64'd0);
        check("write_count", 64'(nwr[k]), 64'(n));
        check("done_count", 64'(done_cnt[k]), 64'd1);
        src_q[k].delete();
    endtask

    initial begin
        int lat;
        int g;
        rst = 1'b1;
        start[0] = 1'b0; start[1] = 1'b0;
        vmode[0] = 0; vmode[1] = 0;
        seed  = {16{32'h5A17_C3E9}};
        nonce = 16'h0102;
        repeat (3) @(negedge clk);
        check("rst_ctrl0", {58'd0, busy[0], done[0], xstart[0], xready[0], xstop[0], we[0]}, 64'd0);
        check("rst_coef0", {aw[0], cdata[0]}, 64'd0);
        check("rst_seed0", {62'd0, |xseed[0], |xnonce[0]}, 64'd0);
        check("rst_ctrl1", {58'd0, busy[1], done[1], xstart[1], xready[1], xstop[1], we[1]}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // ETA=2: 0x00 -> 2,2 ; 0xFE -> -2 then reject ; random tail
        src_q[0].push_back(8'h00);
        src_q[0].push_back(8'hFE);
        repeat (318) src_q[0].push_back(8'($urandom));
        load(0, 2, N0);
        run(0, N0, 1'b0, lat);
        check("a_first_w0", wlog[0][0], {32'd0, 32'd2});
        check("a_first_w1", wlog[0][1], {32'd1, 32'd2});
        check("a_first_w2", wlog[0][2], {32'd2, 32'hFFFF_FFFE});

        // All-zero stream: no rejects, minimum latency
        repeat (136) src_q[0].push_back(8'h00);
        load(0, 2, N0);
        run(0, N0, 1'b0, lat);
        check("b_min_latency", 64'(lat), 64'd274);

        // One full block of rejects, then zeros
        repeat (136) src_q[0].push_back(8'hFF);
        repeat (136) src_q[0].push_back(8'h00);
        load(0, 2, N0);
        run(0, N0, 1'b0, lat);
        check("c_first_write_beats", 64'(first_beats[0]), 64'd17);
`ifdef POLY_ETA_SAMPLER_STATS_EN
        check("c_rej_cnt", {48'd0, rej[0]}, 64'd272);
        check("c_blk_cnt", {56'd0, blk[0]}, 64'd2);
`endif

        // Random valid gaps plus a start pulse while busy
        vmode[0] = 1;
        repeat (320) src_q[0].push_back(8'($urandom));
        load(0, 2, N0);
        run(0, N0, 1'b1, lat);
        vmode[0] = 0;

        // ETA=4: 0x98 -> -4, reject ; 0x40 -> 4, 0
        src_q[1].push_back(8'h98);
        src_q[1].push_back(8'h40);
        repeat (62) src_q[1].push_back(8'($urandom));
        load(1, 4, N1);
        run(1, N1, 1'b0, lat);
        check("e_eta4_w0", wlog[1][0], {32'd0, 32'hFFFF_FFFC});
        check("e_eta4_w1", wlog[1][1], {32'd1, 32'd4});
        check("e_eta4_w2", wlog[1][2], {32'd2, 32'd0});

        // Asynchronous reset in the middle of a polynomial
        repeat (320) src_q[0].push_back(8'($urandom));
        load(0, 2, N0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        g = 0;
        while (!(we[0] && aw[0] == 32'd100) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("f_reached_ctr100", {63'd0, we[0] && aw[0] == 32'd100}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("f_async_ctrl", {58'd0, busy[0], done[0], xstart[0], xready[0], xstop[0], we[0]}, 64'd0);
        check("f_async_coef", {aw[0], cdata[0]}, 64'd0);
        check("f_async_seed", {62'd0, |xseed[0], |xnonce[0]}, 64'd0);
        exp_q[0].delete();
        src_q[0].delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (320) src_q[0].push_back(8'($urandom));
        load(0, 2, N0);
        run(0, N0, 1'b0, lat);
        check("f_restart_addr0", {32'd0, wlog[0][0][63:32]}, 64'd0);

        check("ready_only_in_fetch", 64'(ready_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
